// File: rtl/seg7_scan_decoder.sv
// Seven-segment display bus capture: stability filter, seg->hex decode and frame assembly.
// Define SEG7_SCAN_DECODER_SYNC_EN to place a two-flop synchronizer ahead of the input register.
module seg7_scan_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_in,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  value_valid,
  input  logic                  value_ready,
  output logic                  overrun
);

  localparam int unsigned SampW     = DIGITS + 7;
  localparam int unsigned IdxW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]  StableMax = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StWait0, StCollect, StDeliver} state_e;

  logic [SampW-1:0] pin_w;
  logic [SampW-1:0] front_w;

  assign pin_w = {dig_in, seg_in};

`ifdef SEG7_SCAN_DECODER_SYNC_EN
  logic [SampW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pin_w;
      sync2_q <= sync1_q;
    end
  end

  assign front_w = sync2_q;
`else
  assign front_w = pin_w;
`endif

  // Input register plus the previous sample for change detection.
  logic [SampW-1:0] samp_q, prev_q;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      samp_q <= front_w;
      prev_q <= samp_q;
      cnt_q  <= cnt_d;
    end
  end

  logic [DIGITS-1:0] samp_dig;
  logic [6:0]        samp_seg;
  logic              accept;

  assign samp_dig = samp_q[SampW-1:7];
  assign samp_seg = samp_q[6:0];

  always_comb begin
    cnt_d = cnt_q;
    if (samp_q != prev_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q < StableMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Fires only on the transition into saturation, never while held there.
  assign accept = $onehot(samp_dig) && (cnt_d == StableMax) && (cnt_q != StableMax);

  logic [IdxW-1:0] acc_idx;

  always_comb begin
    acc_idx = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (samp_dig[k]) acc_idx = IdxW'(k);
    end
  end

  // Returns {error, nibble}; unknown patterns decode to 0 with error set.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    unique case (seg)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h70:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h1F:   r = 5'h0B;
      7'h4E:   r = 5'h0C;
      7'h3D:   r = 5'h0D;
      7'h4F:   r = 5'h0E;
      7'h47:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [4:0] dec_w;
  logic [3:0] acc_nib;
  logic       acc_bad;

  assign dec_w   = decode_seg(samp_seg);
  assign acc_nib = dec_w[3:0];
  assign acc_bad = dec_w[4];

  state_e                  state_q, state_d;
  logic [DIGITS-1:0][3:0]  shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]       shadow_err_q, shadow_err_d;
  logic [DIGITS-1:0]       seen_q, seen_d;
  logic [DIGITS-1:0][3:0]  value_q, value_d;
  logic [DIGITS-1:0]       err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWait0;
      shadow_val_q <= '0;
      shadow_err_q <= '0;
      seen_q       <= '0;
      value_q      <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_val_q <= shadow_val_d;
      shadow_err_q <= shadow_err_d;
      seen_q       <= seen_d;
      value_q      <= value_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_val_d = shadow_val_q;
    shadow_err_d = shadow_err_q;
    seen_d       = seen_q;
    value_d      = value_q;
    err_d        = err_q;
    valid_d      = valid_q;
    overrun_d    = 1'b0;

    if (valid_q && value_ready) valid_d = 1'b0;

    unique case (state_q)
      StWait0: begin
        if (accept && (acc_idx == '0)) begin
          shadow_val_d[0] = acc_nib;
          shadow_err_d    = '0;
          shadow_err_d[0] = acc_bad;
          seen_d          = '0;
          seen_d[0]       = 1'b1;
          // A single-digit display completes its frame on this accept.
          state_d         = (&seen_d) ? StDeliver : StCollect;
        end
      end
      StCollect: begin
        if (accept) begin
          if (acc_idx == '0) begin
            shadow_err_d = '0;
            seen_d       = '0;
          end
          shadow_val_d[acc_idx] = acc_nib;
          shadow_err_d[acc_idx] = acc_bad;
          seen_d[acc_idx]       = 1'b1;
        end
        if (&seen_d) state_d = StDeliver;
      end
      StDeliver: begin
        if (!valid_q || value_ready) begin
          value_d = shadow_val_q;
          err_d   = shadow_err_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        state_d = StWait0;
      end
      default: state_d = StWait0;
    endcase
  end

  assign value       = value_q;
  assign digit_err   = err_q;
  assign value_valid = valid_q;
  assign overrun     = overrun_q;

endmodule
